// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine.
//   gcd_state_e   : control FSM states (IDLE, RUN, DONE)
//   MODE_SUBTRACT : algorithm selector value for subtractive Euclid
//   MODE_BINARY   : algorithm selector value for binary (Stein) GCD
//   gcd_flags_t   : compare flags the datapath returns to the FSM
//   k_width()     : width of the common power-of-two counter K
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  localparam int MODE_SUBTRACT = 0;
  localparam int MODE_BINARY   = 1;

  typedef struct packed {
    logic a_zero;
    logic b_zero;
    logic a_eq_b;
    logic a_odd;
  } gcd_flags_t;

  // K counts shared factors of two; it can never exceed WIDTH-1 for
  // non-zero operands, so one extra bit over clog2 is always enough.
  function automatic int k_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/gcd_engine_dp.sv
// GCD datapath: A/B/K working registers, compare, subtract, shift and
// result register.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   load      : capture a_in/b_in into A/B and clear K
//   step      : perform one algorithm step (one RUN edge)
//   a_in,b_in : operands
//   flags     : compare flags for the controlling FSM
//   gcd_out   : result register, holds until the next result is written
module gcd_engine_dp #(
  parameter int WIDTH       = 16,
  parameter int MODE_BINARY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [WIDTH-1:0]    a_in,
  input  logic [WIDTH-1:0]    b_in,
  output gcd_pkg::gcd_flags_t flags,
  output logic [WIDTH-1:0]    gcd_out
);
  import gcd_pkg::*;

  localparam int KW        = k_width(WIDTH);
  localparam bit USE_STEIN = (MODE_BINARY != MODE_SUBTRACT);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k_q;
  logic             a_gt_b;
  logic [WIDTH-1:0] diff;

  assign flags.a_zero = (a_q == '0);
  assign flags.b_zero = (b_q == '0);
  assign flags.a_eq_b = (a_q == b_q);
  assign flags.a_odd  = a_q[0];

  // Always larger minus smaller, so the difference can never wrap.
  assign a_gt_b = (a_q > b_q);
  assign diff   = a_gt_b ? (a_q - b_q) : (b_q - a_q);

  // NOTE: every register here is assigned with <= so that all of them
  // see the pre-edge values of A/B/K within the same step.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      gcd_out <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
      k_q <= '0;
    end else if (step) begin
      // A zero operand can only be present on the first RUN edge: no later
      // step ever produces zero from two non-zero values.
      if (flags.a_zero) begin
        gcd_out <= b_q;
      end else if (flags.b_zero) begin
        gcd_out <= a_q;
      end else if (!USE_STEIN) begin
        if (flags.a_eq_b) gcd_out <= a_q;
        else if (a_gt_b)  a_q     <= diff;
        else              b_q     <= diff;
      end else begin
        // Evenness rules take precedence over equality, so equal even
        // values still have their common factors of two folded into K.
        if (!a_q[0] && !b_q[0]) begin
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          k_q <= k_q + KW'(1);
        end else if (!a_q[0]) begin
          a_q <= a_q >> 1;
        end else if (!b_q[0]) begin
          b_q <= b_q >> 1;
        end else if (flags.a_eq_b) begin
          gcd_out <= a_q << k_q;
        end else if (a_gt_b) begin
          a_q <= diff >> 1;
        end else begin
          b_q <= diff >> 1;
        end
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine top: IDLE/RUN/DONE control FSM plus handshake, wrapped around
// the gcd_engine_dp datapath.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   start      : operand strobe, only honoured while ready=1
//   a_in, b_in : unsigned operands captured with start
//   ready      : high only while IDLE
//   done       : one-cycle result-valid pulse
//   gcd_out    : result, held until the next done
module gcd_engine #(
  parameter int WIDTH       = 16,
  parameter int MODE_BINARY = gcd_pkg::MODE_BINARY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out
);
  import gcd_pkg::*;

  localparam bit USE_STEIN = (MODE_BINARY != MODE_SUBTRACT);

  gcd_state_e state;
  gcd_flags_t flags;
  logic       load;
  logic       step;
  logic       finish;

  assign load = (state == IDLE) && start;
  assign step = (state == RUN);

  // The datapath writes gcd_out on exactly the edges where this is true.
  // In Stein mode equal operands only terminate once they are odd.
  assign finish = flags.a_zero || flags.b_zero ||
                  (flags.a_eq_b && (!USE_STEIN || flags.a_odd));

  // ready/done are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            ready <= 1'b0;
          end
        end
        RUN: begin
          if (finish) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

  gcd_engine_dp #(
    .WIDTH      (WIDTH),
    .MODE_BINARY(MODE_BINARY)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .a_in   (a_in),
    .b_in   (b_in),
    .flags  (flags),
    .gcd_out(gcd_out)
  );

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: one subtractive and one binary instance
// share the clock. Drivers push expected results into a queue as operands
// are issued; a monitor pops and compares on every done pulse, and measures
// the number of edges from the start-sampling edge to done.
module tb_gcd_engine;

  localparam int W         = 16;
  localparam int BIN_BOUND = 2 * W + 2;

  typedef struct {
    int          mode;
    int unsigned gcd;
    int          steps;
    int          k;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst     [2];
  logic         start   [2];
  logic [W-1:0] a_in    [2];
  logic [W-1:0] b_in    [2];
  logic         ready   [2];
  logic         done    [2];
  logic [W-1:0] gcd_out [2];

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   edges   [2];
  bit   pending [2];

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(W), .MODE_BINARY(0)) u_sub (
    .clk(clk), .rst(rst[0]), .start(start[0]), .a_in(a_in[0]), .b_in(b_in[0]),
    .ready(ready[0]), .done(done[0]), .gcd_out(gcd_out[0])
  );

  gcd_engine #(.WIDTH(W), .MODE_BINARY(1)) u_bin (
    .clk(clk), .rst(rst[1]), .start(start[1]), .a_in(a_in[1]), .b_in(b_in[1]),
    .ready(ready[1]), .done(done[1]), .gcd_out(gcd_out[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Edges spent in RUN: one per rewrite of (a,b), plus the terminating edge.
  function automatic int ref_steps(input int mode, input int unsigned a, input int unsigned b);
    int n = 1;
    if (a == 0 || b == 0) return 1;
    while (a != b || (mode == 1 && a % 2 == 0)) begin
      if (mode == 0) begin
        if (a > b) a = a - b;
        else       b = b - a;
      end else if (a % 2 == 0 && b % 2 == 0) begin
        a = a / 2;
        b = b / 2;
      end else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0)     b = b / 2;
      else if (a > b)          a = (a - b) / 2;
      else                     b = (b - a) / 2;
      n++;
    end
    return n;
  endfunction

  // K ends up as the power of two shared by both operands.
  function automatic int ref_k(input int mode, input int unsigned a, input int unsigned b);
    int unsigned g;
    int k = 0;
    if (mode == 0 || a == 0 || b == 0) return 0;
    g = ref_gcd(a, b);
    while (g % 2 == 0) begin
      g = g / 2;
      k++;
    end
    return k;
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (pending[m]) edges[m]++;
      if (ready[m] === 1'b1 && start[m] === 1'b1 && rst[m] === 1'b0) begin
        pending[m] = 1'b1;
        edges[m]   = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (done[m] === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: instance %0d pulsed done with gcd_out=%0d, expected no result", m, gcd_out[m]);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_instance", m, mon_e.mode);
          check("sb_gcd", gcd_out[m], mon_e.gcd);
          check("sb_latency", edges[m], mon_e.steps);
          check("sb_k", (m == 0) ? u_sub.u_dp.k_q : u_bin.u_dp.k_q, mon_e.k);
          if (m == 1) check("bin_latency_bound", edges[m] <= BIN_BOUND, 1);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic push_exp(input int m, input int unsigned g, input int s, input int k);
    exp_t e;
    e.mode = m; e.gcd = g; e.steps = s; e.k = k;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge of the first RUN cycle.
  task automatic issue(input int m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input int unsigned eg, input int es, input int ek);
    int n = 0;
    while (ready[m] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_start", ready[m], 1);
    a_in[m]  = a;
    b_in[m]  = b;
    start[m] = 1'b1;
    if (push) push_exp(m, eg, es, ek);
    @(negedge clk);
    start[m] = 1'b0;
    check("start_accepted", ready[m], 0);
  endtask

  // Returns at the negedge of the DONE cycle (or after the budget expires).
  task automatic wait_done(input int m, input bit toggle);
    int n = 0;
    while (done[m] !== 1'b1 && n < 2000) begin
      if (toggle) begin
        start[m] = ~start[m];
        a_in[m]  = W'($urandom);
        b_in[m]  = W'($urandom);
      end
      @(negedge clk);
      n++;
    end
    check("done_within_budget", done[m], 1);
  endtask

  task automatic finish_pulse(input int m);
    @(negedge clk);
    check("done_one_cycle", done[m], 0);
    check("ready_after_done", ready[m], 1);
  endtask

  task automatic run_op(input int m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int unsigned eg, input int es, input int ek);
    issue(m, a, b, 1'b1, eg, es, ek);
    wait_done(m, 1'b0);
    finish_pulse(m);
  endtask

  task automatic run_model(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
    run_op(m, a, b, ref_gcd(a, b), ref_steps(m, a, b), ref_k(m, a, b));
  endtask

  // Reset lands on the edge closing the 3rd RUN cycle.
  task automatic abort_case(input int m);
    bit saw_done = 1'b0;
    issue(m, 16'd143, 16'd78, 1'b0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst[m] = 1'b1;
    @(negedge clk);
    rst[m] = 1'b0;
    check("abort_ready", ready[m], 1);
    check("abort_done", done[m], 0);
    check("abort_gcd_out", gcd_out[m], 0);
    repeat (12) begin
      @(negedge clk);
      if (done[m] === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_late_done", saw_done, 0);
  endtask

  // start toggles through RUN and DONE, then a second operation is started
  // on the IDLE cycle right after DONE.
  task automatic toggle_case(input int m);
    issue(m, 16'd143, 16'd78, 1'b1, 13, ref_steps(m, 143, 78), ref_k(m, 143, 78));
    wait_done(m, 1'b1);
    a_in[m]  = 16'd48;
    b_in[m]  = 16'd18;
    start[m] = 1'b1;
    @(negedge clk);
    check("b2b_idle_ready", ready[m], 1);
    check("b2b_idle_no_done", done[m], 0);
    push_exp(m, ref_gcd(48, 18), ref_steps(m, 48, 18), ref_k(m, 48, 18));
    @(negedge clk);
    start[m] = 1'b0;
    check("b2b_accepted", ready[m], 0);
    wait_done(m, 1'b0);
    finish_pulse(m);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int m = 0; m < 2; m++) begin
      rst[m] = 1'b1; start[m] = 1'b0; a_in[m] = '0; b_in[m] = '0;
      edges[m] = 0; pending[m] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int m = 0; m < 2; m++) begin
      check("reset_ready", ready[m], 1);
      check("reset_done", done[m], 0);
      check("reset_gcd_out", gcd_out[m], 0);
    end

    // Worked examples with hand-derived latency.
    run_op(0, 16'd143, 16'd78, 13, 7, 0);
    run_op(1, 16'd143, 16'd78, 13, 6, 0);

    for (int m = 0; m < 2; m++) begin
      abort_case(m);
      run_op(m, 16'd12, 16'd8, 4, ref_steps(m, 12, 8), ref_k(m, 12, 8));
    end

    run_op(1, 16'd48, 16'd18, 6, 6, 1);

    for (int m = 0; m < 2; m++) begin
      run_op(m, 16'd0,  16'd25, 25, 1, 0);
      run_op(m, 16'd25, 16'd0,  25, 1, 0);
      run_op(m, 16'd0,  16'd0,  0,  1, 0);
    end

    for (int m = 0; m < 2; m++) toggle_case(m);

    repeat (12) run_model(1, W'($urandom), W'($urandom));
    repeat (8)  run_model(0, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
    run_model(1, 16'hFFFF, 16'h0001);
    run_model(1, 16'h8000, 16'h8000);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
